// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: converts a held load/store into a registered request
// on a multi-cycle data-memory port and freezes the pipeline until the access completes.
module mem_access_ctrl #(
    parameter int DW       = 16,
    parameter int AW       = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          MEM_MemRead,
    input  logic          MEM_MemWrite,
    input  logic [AW-1:0] MEM_ALUval,
    input  logic [DW-1:0] MEM_StoreData,
    input  logic          freeze_in,
    output logic [DW-1:0] MEM_ReadData,
    output logic          mem_stall,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          mem_err
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    // Counter value of the last WAIT cycle allowed before the access is abandoned.
    localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

    state_t        state;
    logic [7:0]    wait_cnt;
    logic [DW-1:0] rdata_q;
    logic          access;
    logic          in_wait;
    logic          ack_hit;
    logic          timeout;

    assign access  = MEM_MemRead | MEM_MemWrite;
    assign in_wait = (state == WAIT);
    assign ack_hit = in_wait & mem_ack;
    assign timeout = in_wait & ~mem_ack & (wait_cnt == LAST_CNT);

    // Load data is bypassed on the ack cycle so MEM/WB captures it on that same edge.
    assign MEM_ReadData = (ack_hit & ~mem_wr) ? mem_rdata : rdata_q;

    always_comb begin
        mem_stall = 1'b0;
        case (state)
            IDLE:    mem_stall = access;
            WAIT:    mem_stall = ~mem_ack & ~timeout;
            default: mem_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_err   <= 1'b0;
            rdata_q   <= '0;
            wait_cnt  <= '0;
        end else begin
            mem_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        mem_addr  <= {MEM_ALUval[AW-1:1], 1'b0};
                        mem_wdata <= MEM_StoreData;
                        mem_wr    <= MEM_MemWrite;
                        mem_en    <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        if (!mem_wr) rdata_q <= mem_rdata;
                        state <= freeze_in ? HOLD : IDLE;
                    end else if (timeout) begin
                        mem_err <= 1'b1;
                        rdata_q <= '0;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    // Access is done; the instruction stays in MEM until the external freeze lifts.
                    if (!freeze_in) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a vector table for load/store/back-to-back traffic,
// then hand-written sequences for freeze hold, timeout and asynchronous reset.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MEM_MemRead, MEM_MemWrite, freeze_in, mem_ack;
    logic [15:0] MEM_ALUval, MEM_StoreData, mem_rdata;
    logic [15:0] MEM_ReadData, mem_addr, mem_wdata;
    logic        mem_stall, mem_en, mem_wr, mem_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DW(16), .AW(16), .MAX_WAIT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
        .MEM_ALUval(MEM_ALUval), .MEM_StoreData(MEM_StoreData),
        .freeze_in(freeze_in), .MEM_ReadData(MEM_ReadData),
        .mem_stall(mem_stall), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
    );

    typedef struct {
        logic        rd, wr;
        logic [15:0] addr, sdata;
        logic        frz, ack;
        logic [15:0] rdin;
        logic        e_stall, e_en, e_wr;
        logic [15:0] e_addr, e_wdata, e_rd;
        logic        e_err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic rd, logic wr, logic [15:0] addr, logic [15:0] sdata,
                                logic frz, logic ack, logic [15:0] rdin,
                                logic e_stall, logic e_en, logic e_wr, logic [15:0] e_addr,
                                logic [15:0] e_wdata, logic [15:0] e_rd, logic e_err);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.sdata = sdata; v.frz = frz; v.ack = ack;
        v.rdin = rdin; v.e_stall = e_stall; v.e_en = e_en; v.e_wr = e_wr; v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_rd = e_rd; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic rd, logic wr, logic [15:0] addr, logic [15:0] sdata,
                         logic frz, logic ack, logic [15:0] rdin);
        MEM_MemRead = rd; MEM_MemWrite = wr; MEM_ALUval = addr; MEM_StoreData = sdata;
        freeze_in = frz; mem_ack = ack; mem_rdata = rdin;
    endtask

    // Step to just after the next rising edge; inputs for the new cycle are driven here.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_en", mem_en, 0);
        chk("reset_wr", mem_wr, 0);
        chk("reset_err", mem_err, 0);
        chk("reset_addr", mem_addr, 16'h0);
        chk("reset_wdata", mem_wdata, 16'h0);
        chk("reset_rdata", MEM_ReadData, 16'h0);
        chk("reset_stall", mem_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // rd wr addr sdata frz ack rdin | stall en wr addr wdata rdout err
        vq.push_back(mk(1,0,16'h1235,16'h0000,0,0,16'h0000, 1,0,0,16'h0000,16'h0000,16'h0000,0));
        vq.push_back(mk(1,0,16'h1235,16'h0000,0,0,16'h0000, 1,1,0,16'h1234,16'h0000,16'h0000,0));
        vq.push_back(mk(1,0,16'h1235,16'h0000,0,0,16'h0000, 1,0,0,16'h1234,16'h0000,16'h0000,0));
        vq.push_back(mk(1,0,16'h1235,16'h0000,0,0,16'h0000, 1,0,0,16'h1234,16'h0000,16'h0000,0));
        vq.push_back(mk(1,0,16'h1235,16'h0000,0,1,16'hBEEF, 0,0,0,16'h1234,16'h0000,16'hBEEF,0));
        vq.push_back(mk(0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,0,16'h1234,16'h0000,16'hBEEF,0));
        vq.push_back(mk(0,1,16'h0040,16'hA5A5,0,0,16'h0000, 1,0,0,16'h1234,16'h0000,16'hBEEF,0));
        vq.push_back(mk(0,1,16'h0040,16'hA5A5,0,1,16'hBEEF, 0,1,1,16'h0040,16'hA5A5,16'hBEEF,0));
        vq.push_back(mk(0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,1,16'h0040,16'hA5A5,16'hBEEF,0));
        vq.push_back(mk(1,0,16'h0010,16'h0000,0,0,16'h0000, 1,0,1,16'h0040,16'hA5A5,16'hBEEF,0));
        vq.push_back(mk(1,0,16'h0010,16'h0000,0,1,16'h1111, 0,1,0,16'h0010,16'h0000,16'h1111,0));
        vq.push_back(mk(1,0,16'h0012,16'h0000,0,0,16'h0000, 1,0,0,16'h0010,16'h0000,16'h1111,0));
        vq.push_back(mk(1,0,16'h0012,16'h0000,0,1,16'h2222, 0,1,0,16'h0012,16'h0000,16'h2222,0));
        vq.push_back(mk(0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,0,16'h0012,16'h0000,16'h2222,0));

        foreach (vq[i]) begin
            next_cycle();
            drive(vq[i].rd, vq[i].wr, vq[i].addr, vq[i].sdata, vq[i].frz, vq[i].ack, vq[i].rdin);
            #1;
            chk($sformatf("row%0d_stall", i), mem_stall, vq[i].e_stall);
            chk($sformatf("row%0d_en", i), mem_en, vq[i].e_en);
            chk($sformatf("row%0d_wr", i), mem_wr, vq[i].e_wr);
            chk($sformatf("row%0d_addr", i), mem_addr, vq[i].e_addr);
            chk($sformatf("row%0d_wdata", i), mem_wdata, vq[i].e_wdata);
            chk($sformatf("row%0d_rdata", i), MEM_ReadData, vq[i].e_rd);
            chk($sformatf("row%0d_err", i), mem_err, vq[i].e_err);
        end

        // Load completes while freeze_in holds the pipeline: HOLD, no re-issue.
        next_cycle(); drive(1, 0, 16'h0100, 16'h0, 1, 0, 16'h0); #1;
        chk("hold_issue_stall", mem_stall, 1);
        next_cycle(); drive(1, 0, 16'h0100, 16'h0, 1, 1, 16'h3333); #1;
        chk("hold_ack_en", mem_en, 1);
        chk("hold_ack_stall", mem_stall, 0);
        chk("hold_ack_rdata", MEM_ReadData, 16'h3333);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            drive(1, 0, 16'h0100, 16'h0, 1, (k == 1), 16'h9999);
            #1;
            chk($sformatf("hold%0d_stall", k), mem_stall, 0);
            chk($sformatf("hold%0d_en", k), mem_en, 0);
            chk($sformatf("hold%0d_rdata", k), MEM_ReadData, 16'h3333);
        end
        next_cycle(); drive(1, 0, 16'h0100, 16'h0, 0, 0, 16'h0); #1;
        chk("hold_release_stall", mem_stall, 0);
        chk("hold_release_en", mem_en, 0);
        next_cycle(); drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0); #1;
        chk("hold_after_en", mem_en, 0);
        chk("hold_after_rdata", MEM_ReadData, 16'h3333);

        // No ack: the 15th WAIT cycle aborts with a sticky error.
        next_cycle(); drive(1, 0, 16'h0200, 16'h0, 0, 0, 16'h0); #1;
        chk("to_issue_stall", mem_stall, 1);
        for (int k = 1; k <= 15; k++) begin
            next_cycle();
            drive(1, 0, 16'h0200, 16'h0, 0, 0, 16'h0);
            #1;
            chk($sformatf("to_w%0d_stall", k), mem_stall, (k < 15));
            if (k == 1) chk("to_w1_en", mem_en, 1);
            if (k == 14) chk("to_w14_err", mem_err, 0);
        end
        next_cycle(); drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0); #1;
        chk("to_err", mem_err, 1);
        chk("to_rdata", MEM_ReadData, 16'h0000);
        chk("to_stall", mem_stall, 0);
        next_cycle(); drive(1, 0, 16'h0300, 16'h0, 0, 0, 16'h0); #1;
        chk("to_next_stall", mem_stall, 1);
        next_cycle(); drive(1, 0, 16'h0300, 16'h0, 0, 1, 16'h4444); #1;
        chk("to_next_en", mem_en, 1);
        chk("to_next_addr", mem_addr, 16'h0300);
        chk("to_next_rdata", MEM_ReadData, 16'h4444);
        chk("to_err_sticky", mem_err, 1);

        // Asynchronous reset in the middle of a store, then a late ack.
        next_cycle(); drive(0, 1, 16'h0400, 16'h1234, 0, 0, 16'h0); #1;
        chk("rst_issue_stall", mem_stall, 1);
        next_cycle(); drive(0, 1, 16'h0400, 16'h1234, 0, 0, 16'h0); #1;
        chk("rst_pre_en", mem_en, 1);
        chk("rst_pre_wr", mem_wr, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_en", mem_en, 0);
        chk("rst_async_wr", mem_wr, 0);
        chk("rst_async_addr", mem_addr, 16'h0);
        chk("rst_async_wdata", mem_wdata, 16'h0);
        chk("rst_async_err", mem_err, 0);
        chk("rst_async_rdata", MEM_ReadData, 16'h0);
        drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
        #1;
        chk("rst_async_stall", mem_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle(); drive(0, 0, 16'h0, 16'h0, 0, 1, 16'h5555); #1;
        chk("late_ack_rdata", MEM_ReadData, 16'h0);
        chk("late_ack_stall", mem_stall, 0);
        chk("late_ack_en", mem_en, 0);
        next_cycle(); drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0); #1;
        chk("late_ack_after_rdata", MEM_ReadData, 16'h0);
        chk("late_ack_after_en", mem_en, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
